// File: rtl/uart_fifo_xcvr.sv
// Full-duplex UART with RX FIFO, configurable frame width and baud divisor.
// Define UART_PARITY_EN to add an even parity bit after the data bits.
module uart_fifo_xcvr #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned BAUD_DIV   = 2604,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              trmt,
   input  logic [DATA_W-1:0] tx_data,
   output logic              TX,
   output logic              tx_done,
   input  logic              RX,
   output logic              rdy,
   output logic [DATA_W-1:0] rx_data,
   input  logic              clr_rdy,
   output logic              rx_err,
   output logic              rx_ovfl,
   input  logic              clr_ovfl
);

`ifdef UART_PARITY_EN
   localparam int unsigned ParW = 1;
`else
   localparam int unsigned ParW = 0;
`endif
   localparam int unsigned FrameW = DATA_W + 2 + ParW;
   localparam int unsigned BaudCw = $clog2(BAUD_DIV);
   localparam int unsigned BitCw  = $clog2(FrameW);
   localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);

   localparam logic [BaudCw-1:0] BaudLast  = BaudCw'(BAUD_DIV - 1);
   localparam logic [BaudCw-1:0] BaudHalf  = BaudCw'(BAUD_DIV / 2);
   localparam logic [BitCw-1:0]  TxBitLast = BitCw'(FrameW - 1);
   localparam logic [BitCw-1:0]  RxBitLast = BitCw'(DATA_W + ParW - 1);
   localparam logic [CntW-1:0]   FifoFull  = CntW'(FIFO_DEPTH);

   // ---------------- TX ----------------
   typedef enum logic {TxIdle, TxXmit} tx_state_e;

   tx_state_e          tx_state_q, tx_state_d;
   logic [FrameW-1:0]  tx_sh_q, tx_sh_d;
   logic [BaudCw-1:0]  tx_baud_q, tx_baud_d;
   logic [BitCw-1:0]   tx_bit_q, tx_bit_d;
   logic               tx_done_q, tx_done_d;
   logic [FrameW-1:0]  tx_frame;

`ifdef UART_PARITY_EN
   assign tx_frame = {1'b1, ^tx_data, tx_data, 1'b0};
`else
   assign tx_frame = {1'b1, tx_data, 1'b0};
`endif

   always_comb begin
      tx_state_d = tx_state_q;
      tx_sh_d    = tx_sh_q;
      tx_baud_d  = tx_baud_q;
      tx_bit_d   = tx_bit_q;
      tx_done_d  = tx_done_q;
      unique case (tx_state_q)
         TxIdle: begin
            if (trmt) begin
               tx_state_d = TxXmit;
               tx_sh_d    = tx_frame;
               tx_baud_d  = '0;
               tx_bit_d   = '0;
               tx_done_d  = 1'b0;
            end
         end
         TxXmit: begin
            if (tx_baud_q == BaudLast) begin
               tx_baud_d = '0;
               // Shift in ones so the line rests high once the stop bit is gone.
               tx_sh_d   = {1'b1, tx_sh_q[FrameW-1:1]};
               if (tx_bit_q == TxBitLast) begin
                  tx_state_d = TxIdle;
                  tx_done_d  = 1'b1;
               end else begin
                  tx_bit_d = tx_bit_q + 1'b1;
               end
            end else begin
               tx_baud_d = tx_baud_q + 1'b1;
            end
         end
         default: tx_state_d = TxIdle;
      endcase
   end

   assign TX      = tx_sh_q[0];
   assign tx_done = tx_done_q;

   // ---------------- RX ----------------
   typedef enum logic [1:0] {RxIdle, RxStart, RxBits, RxStop} rx_state_e;

   rx_state_e          rx_state_q, rx_state_d;
   logic               rx_meta_q, rx_sync_q, rx_prev_q;
   logic [DATA_W-1:0]  rx_sh_q, rx_sh_d;
   logic [BaudCw-1:0]  rx_baud_q, rx_baud_d;
   logic [BitCw-1:0]   rx_bit_q, rx_bit_d;
   logic               rx_err_q, rx_err_d;
   logic               push;
   logic               par_bad;

`ifdef UART_PARITY_EN
   logic rx_par_q, rx_par_d;
   assign par_bad = rx_par_q ^ (^rx_sh_q);
`else
   assign par_bad = 1'b0;
`endif

   always_comb begin
      rx_state_d = rx_state_q;
      rx_sh_d    = rx_sh_q;
      rx_baud_d  = rx_baud_q;
      rx_bit_d   = rx_bit_q;
      rx_err_d   = 1'b0;
      push       = 1'b0;
`ifdef UART_PARITY_EN
      rx_par_d   = rx_par_q;
`endif
      unique case (rx_state_q)
         RxIdle: begin
            if (rx_prev_q && !rx_sync_q) begin
               rx_state_d = RxStart;
               rx_baud_d  = '0;
            end
         end
         RxStart: begin
            if (rx_baud_q == BaudHalf) begin
               rx_baud_d = '0;
               rx_bit_d  = '0;
               // A line already back high at mid start bit is a glitch.
               rx_state_d = rx_sync_q ? RxIdle : RxBits;
            end else begin
               rx_baud_d = rx_baud_q + 1'b1;
            end
         end
         RxBits: begin
            if (rx_baud_q == BaudLast) begin
               rx_baud_d = '0;
`ifdef UART_PARITY_EN
               if (rx_bit_q == RxBitLast) rx_par_d = rx_sync_q;
               else rx_sh_d = {rx_sync_q, rx_sh_q[DATA_W-1:1]};
`else
               rx_sh_d = {rx_sync_q, rx_sh_q[DATA_W-1:1]};
`endif
               if (rx_bit_q == RxBitLast) rx_state_d = RxStop;
               else rx_bit_d = rx_bit_q + 1'b1;
            end else begin
               rx_baud_d = rx_baud_q + 1'b1;
            end
         end
         RxStop: begin
            if (rx_baud_q == BaudLast) begin
               rx_baud_d  = '0;
               rx_state_d = RxIdle;
               if (!rx_sync_q || par_bad) rx_err_d = 1'b1;
               else push = 1'b1;
            end else begin
               rx_baud_d = rx_baud_q + 1'b1;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   assign rx_err = rx_err_q;

   // ---------------- FIFO ----------------
   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   cnt_q;
   logic              full, pop, wr_en, ovfl_q;

   assign full  = (cnt_q == FifoFull);
   assign pop   = clr_rdy && (cnt_q != '0);
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign wr_en = push && (!full || pop);

   assign rdy     = (cnt_q != '0);
   assign rx_data = fifo_mem[rd_ptr_q];
   assign rx_ovfl = ovfl_q;

   always_ff @(posedge clk) begin
      if (wr_en) fifo_mem[wr_ptr_q] <= rx_sh_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_state_q <= TxIdle;
         tx_sh_q    <= '1;
         tx_baud_q  <= '0;
         tx_bit_q   <= '0;
         tx_done_q  <= 1'b0;
         rx_state_q <= RxIdle;
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_sh_q    <= '0;
         rx_baud_q  <= '0;
         rx_bit_q   <= '0;
         rx_err_q   <= 1'b0;
`ifdef UART_PARITY_EN
         rx_par_q   <= 1'b0;
`endif
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         ovfl_q     <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_sh_q    <= tx_sh_d;
         tx_baud_q  <= tx_baud_d;
         tx_bit_q   <= tx_bit_d;
         tx_done_q  <= tx_done_d;
         rx_state_q <= rx_state_d;
         rx_meta_q  <= RX;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
         rx_sh_q    <= rx_sh_d;
         rx_baud_q  <= rx_baud_d;
         rx_bit_q   <= rx_bit_d;
         rx_err_q   <= rx_err_d;
`ifdef UART_PARITY_EN
         rx_par_q   <= rx_par_d;
`endif
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
         if (wr_en && !pop)      cnt_q <= cnt_q + 1'b1;
         else if (pop && !wr_en) cnt_q <= cnt_q - 1'b1;
         if (push && full && !pop) ovfl_q <= 1'b1;
         else if (clr_ovfl)        ovfl_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_fifo_xcvr.sv
// Self-checking bench for uart_fifo_xcvr: loopback plus directly driven RX frames,
// with a queue of expected received words.
module tb_uart_fifo_xcvr;

`ifdef UART_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int BD = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       trmt = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_line, tx_done, rdy, rx_err, rx_ovfl;
   logic [7:0] rx_data;
   logic       clr_rdy = 1'b0;
   logic       clr_ovfl = 1'b0;
   logic       loop_en = 1'b1;
   logic       rx_drv = 1'b1;
   logic       rx_in;

   assign rx_in = loop_en ? tx_line : rx_drv;

   always #5 clk = ~clk;

   uart_fifo_xcvr #(.DATA_W(8), .BAUD_DIV(BD), .FIFO_DEPTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .trmt     (trmt),
      .tx_data  (tx_data),
      .TX       (tx_line),
      .tx_done  (tx_done),
      .RX       (rx_in),
      .rdy      (rdy),
      .rx_data  (rx_data),
      .clr_rdy  (clr_rdy),
      .rx_err   (rx_err),
      .rx_ovfl  (rx_ovfl),
      .clr_ovfl (clr_ovfl)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q [$];

   int   err_hi = 0;
   int   err_pulses = 0;
   logic err_prev = 1'b0;

   always @(negedge clk) begin
      if (rx_err) err_hi++;
      if (rx_err && !err_prev) err_pulses++;
      err_prev = rx_err;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic start_tx(input logic [7:0] d);
      @(negedge clk);
      tx_data = d;
      trmt    = 1'b1;
      @(negedge clk);
      trmt    = 1'b0;
   endtask

   // Also fires a trmt mid-frame, which must be ignored.
   task automatic wait_done(input string tag, input logic [7:0] ign);
      int cyc = 0;
      check({tag, "_start"}, {30'd0, tx_done, tx_line}, 32'd0);
      while (!tx_done && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 20) begin
            tx_data = ign;
            trmt    = 1'b1;
         end else if (cyc == 21) begin
            trmt = 1'b0;
         end
      end
      trmt = 1'b0;
      check({tag, "_lat"}, cyc, NB * BD);
   endtask

   task automatic pop_check(input string tag);
      int cyc = 0;
      logic [7:0] e;
      while (!rdy && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
      check({tag, "_sb"}, exp_q.size() != 0, 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_data"}, {24'd0, rx_data}, {24'd0, e});
      end
      clr_rdy = 1'b1;
      @(negedge clk);
      clr_rdy = 1'b0;
   endtask

   task automatic drive_frame(input logic [7:0] d, input logic par, input logic stop);
      rx_drv = 1'b0;
      repeat (BD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         repeat (BD) @(negedge clk);
      end
`ifdef UART_PARITY_EN
      rx_drv = par;
      repeat (BD) @(negedge clk);
`endif
      rx_drv = stop;
      repeat (BD) @(negedge clk);
      rx_drv = 1'b1;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, h0;
      // 1: reset
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_tx", {31'd0, tx_line}, 32'd1);
      check("rst_state", {28'd0, tx_done, rdy, rx_err, rx_ovfl}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // 2: single word loopback
      start_tx(8'hA5);
      exp_q.push_back(8'hA5);
      wait_done("a5", 8'h3C);
      pop_check("a5");
      check("a5_rdy_clr", {31'd0, rdy}, 32'd0);
      check("a5_done_hold", {31'd0, tx_done}, 32'd1);

      // 3: full data sweep
      for (int i = 0; i < 256; i++) begin
         start_tx(8'(i));
         exp_q.push_back(8'(i));
         wait_done("sweep", ~8'(i));
         pop_check("sweep");
      end
      check("sweep_noerr", err_pulses, 32'd0);
      check("sweep_empty", {31'd0, rdy}, 32'd0);

      // 4: overflow
      for (int k = 0; k < 5; k++) begin
         start_tx(8'h11 * 8'(k + 1));
         if (k < 4) exp_q.push_back(8'h11 * 8'(k + 1));
         wait_done("ovf", 8'hFF);
         check("ovf_flag", {31'd0, rx_ovfl}, (k == 4) ? 32'd1 : 32'd0);
      end
      for (int k = 0; k < 4; k++) pop_check("ovf_pop");
      check("ovf_empty", {31'd0, rdy}, 32'd0);
      check("ovf_sticky", {31'd0, rx_ovfl}, 32'd1);
      clr_ovfl = 1'b1;
      @(negedge clk);
      clr_ovfl = 1'b0;
      check("ovf_clr", {31'd0, rx_ovfl}, 32'd0);

      // 5: start glitch then valid frame
      loop_en = 1'b0;
      p0 = err_pulses;
      rx_drv = 1'b0;
      repeat (4) @(negedge clk);
      rx_drv = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_rdy", {31'd0, rdy}, 32'd0);
      check("glitch_err", err_pulses - p0, 32'd0);
      drive_frame(8'h3C, ^8'h3C, 1'b1);
      exp_q.push_back(8'h3C);
      pop_check("post_glitch");
      check("post_glitch_empty", {31'd0, rdy}, 32'd0);

      // 6: framing error (and parity error when enabled)
      p0 = err_pulses;
      h0 = err_hi;
      drive_frame(8'h5A, ^8'h5A, 1'b0);
      repeat (20) @(negedge clk);
      check("frm_err_pulses", err_pulses - p0, 32'd1);
      check("frm_err_width", err_hi - h0, 32'd1);
      check("frm_rdy", {31'd0, rdy}, 32'd0);
`ifdef UART_PARITY_EN
      p0 = err_pulses;
      h0 = err_hi;
      drive_frame(8'h5A, ~(^8'h5A), 1'b1);
      repeat (20) @(negedge clk);
      check("par_err_pulses", err_pulses - p0, 32'd1);
      check("par_err_width", err_hi - h0, 32'd1);
      check("par_rdy", {31'd0, rdy}, 32'd0);
`endif

      // 7: reset mid-frame aborts without pushing
      loop_en = 1'b1;
      repeat (5) @(negedge clk);
      start_tx(8'h77);
      repeat (50) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_tx", {31'd0, tx_line}, 32'd1);
      check("mid_rst_state", {29'd0, tx_done, rdy, rx_ovfl}, 32'd0);
      repeat (300) @(negedge clk);
      check("mid_rst_nopush", {31'd0, rdy}, 32'd0);
      check("mid_rst_tx_idle", {31'd0, tx_line}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
